// File: rtl/bpsk_pkg.sv
// Shared constants and types for the BPSK packet chain (serializer, modulator, deframer).
package bpsk_pkg;

   localparam int unsigned PACKET_SIZE   = 192;
   localparam int unsigned SYNC_WIDTH    = 8;
   localparam logic [SYNC_WIDTH-1:0] SYNC_WORD = 8'hFF;

   localparam int unsigned PAYLOAD_WIDTH = PACKET_SIZE - SYNC_WIDTH;
   localparam int unsigned COUNT_WIDTH   = $clog2(PAYLOAD_WIDTH + 1);

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } deframer_state_t;

   typedef logic [PACKET_SIZE-1:0]   packet_t;
   typedef logic [PAYLOAD_WIDTH-1:0] payload_t;

endpackage

// File: rtl/packet_deframer_sync_detector.sv
// Sync header hunter: shift register plus comparator(s) on the post-shift window.
// Optional feature macro: PACKET_DEFRAMER_PHASE_RESOLVE_EN (adds inverted-header match).
module sync_detector
   import bpsk_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic bit_in,
   input  logic shift_en,
   input  logic clear,
   output logic match_c
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
   ,
   output logic inverted_match_c
`endif
);

   logic [SYNC_WIDTH-1:0] hunt_q;
   logic [SYNC_WIDTH-1:0] shifted_c;

   assign shifted_c = {hunt_q[SYNC_WIDTH-2:0], bit_in};

   // Hunt window: new bits enter at the LSB; cleared on reset or on packet completion.
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         hunt_q <= '0;
      end else if (shift_en) begin
         hunt_q <= shifted_c;
      end
   end

   assign match_c = shift_en && (shifted_c == SYNC_WORD);

`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
   assign inverted_match_c = shift_en && (shifted_c == ~SYNC_WORD);
`endif

endmodule

// File: rtl/packet_deframer.sv
// Packet deframer: hunts for the sync header, collects one fixed-length packet and
// offers it through a one-deep valid/ready buffer.
// Optional feature macro: PACKET_DEFRAMER_PHASE_RESOLVE_EN (180-degree phase resolve,
// adds the 'inverted' output).
module packet_deframer
   import bpsk_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   bit_in,
   input  logic                   bit_valid,
   output logic [PACKET_SIZE-1:0] pkt_data,
   output logic                   pkt_valid,
   input  logic                   pkt_ready,
   output logic                   locked,
   output logic                   overflow
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
   ,
   output logic                   inverted
`endif
);

   deframer_state_t        state, state_next;
   logic [COUNT_WIDTH-1:0] count, count_next;
   payload_t               payload, payload_next;
   packet_t                pkt_data_next;
   logic                   pkt_valid_next;
   logic                   overflow_next;
   logic                   locked_next;
   logic                   hunt_shift_c;
   logic                   hunt_clear_c;
   logic                   match_c;
   logic                   complete_c;
   logic                   data_bit_c;

`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
   logic                   inv_match_c;
   logic                   inverted_next;
   assign data_bit_c = bit_in ^ inverted;
`else
   assign data_bit_c = bit_in;
`endif

   assign hunt_shift_c = bit_valid && (state == HUNT);

   sync_detector u_sync_detector (
      .clk              (clk),
      .rstn             (rstn),
      .bit_in           (bit_in),
      .shift_en         (hunt_shift_c),
      .clear            (hunt_clear_c),
      .match_c          (match_c)
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
      ,
      .inverted_match_c (inv_match_c)
`endif
   );

   // Next-state, collect datapath and output buffer decisions.
   always_comb begin
      state_next     = state;
      count_next     = count;
      payload_next   = payload;
      pkt_data_next  = pkt_data;
      pkt_valid_next = pkt_valid;
      overflow_next  = 1'b0;
      hunt_clear_c   = 1'b0;
      complete_c     = 1'b0;
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
      inverted_next  = inverted;
`endif

      case (state)
         HUNT: begin
            if (match_c) begin
               state_next = COLLECT;
               count_next = '0;
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
               inverted_next = 1'b0;
            end else if (inv_match_c) begin
               state_next    = COLLECT;
               count_next    = '0;
               inverted_next = 1'b1;
`endif
            end
         end
         COLLECT: begin
            if (bit_valid) begin
               payload_next = {payload[PAYLOAD_WIDTH-2:0], data_bit_c};
               count_next   = count + COUNT_WIDTH'(1);
               if (count == COUNT_WIDTH'(PAYLOAD_WIDTH - 1)) begin
                  complete_c   = 1'b1;
                  state_next   = HUNT;
                  count_next   = '0;
                  hunt_clear_c = 1'b1;
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
                  inverted_next = 1'b0;
`endif
               end
            end
         end
      endcase

      // A completion wins over a plain consume; a completion into a full, stalled buffer is dropped.
      if (complete_c) begin
         if (!pkt_valid || pkt_ready) begin
            pkt_data_next  = {SYNC_WORD, payload_next};
            pkt_valid_next = 1'b1;
         end else begin
            overflow_next = 1'b1;
         end
      end else if (pkt_valid && pkt_ready) begin
         pkt_valid_next = 1'b0;
      end

      locked_next = (state_next == COLLECT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= HUNT;
         count     <= '0;
         payload   <= '0;
         pkt_data  <= '0;
         pkt_valid <= 1'b0;
         overflow  <= 1'b0;
         locked    <= 1'b0;
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
         inverted  <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         count     <= count_next;
         payload   <= payload_next;
         pkt_data  <= pkt_data_next;
         pkt_valid <= pkt_valid_next;
         overflow  <= overflow_next;
         locked    <= locked_next;
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
         inverted  <= inverted_next;
`endif
      end
   end

endmodule

// File: tb/tb_packet_deframer.sv
// Self-checking bench for packet_deframer: directed scenarios plus randomized traffic,
// checked every cycle against a bit-queue model of the deframing rules.
// Honours PACKET_DEFRAMER_PHASE_RESOLVE_EN when defined.
module tb_packet_deframer;

   localparam int PKT  = 192;
   localparam int SYNC = 8;
   localparam int PAY  = PKT - SYNC;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic pkt_ready = 1'b1;
   logic [PKT-1:0] pkt_data;
   logic pkt_valid;
   logic locked;
   logic overflow;
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
   logic inverted;
`endif

   packet_deframer dut (
      .clk       (clk),
      .rstn      (rstn),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .pkt_data  (pkt_data),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .locked    (locked),
      .overflow  (overflow)
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
      ,
      .inverted  (inverted)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   bit rnd = 1'b0;

   logic [PKT-1:0] p1 = 192'hff5468697320697320612074657374206d65737361676521;
   logic [PKT-1:0] p2 = {8'hFF, {23{8'h55}}};
   logic [PKT-1:0] pn;

   task automatic chk(input string nm, input logic [PKT-1:0] act, input logic [PKT-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: hunt window as an 8-bit number, payload as a bit queue.
   logic [PKT-1:0] m_data = '0;
   bit m_valid = 0, m_locked = 0, m_ovf = 0, m_inv = 0;
   int m_win = 0;
   bit col_q[$];

   task automatic model_step();
      bit done;
      logic [PKT-1:0] pk;
      done = 0;
      pk = '0;
      if (!rstn) begin
         m_win = 0; col_q.delete(); m_locked = 0; m_valid = 0;
         m_data = '0; m_ovf = 0; m_inv = 0;
         return;
      end
      if (bit_valid) begin
         if (!m_locked) begin
            m_win = ((m_win << 1) | int'(bit_in)) & 255;
            if (m_win == 255) m_locked = 1;
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
            else if (m_win == 0) begin
               m_locked = 1;
               m_inv = 1;
            end
`endif
         end else begin
            col_q.push_back(bit'(bit_in) ^ m_inv);
            if (col_q.size() == PAY) begin
               pk[PKT-1 -: SYNC] = 8'hFF;
               for (int i = 0; i < PAY; i++) pk[PAY-1-i] = col_q[i];
               done = 1;
               col_q.delete();
               m_locked = 0; m_inv = 0; m_win = 0;
            end
         end
      end
      m_ovf = 0;
      if (done) begin
         if (!m_valid || pkt_ready) begin
            m_data = pk;
            m_valid = 1;
         end else begin
            m_ovf = 1;
         end
      end else if (m_valid && pkt_ready) begin
         m_valid = 0;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison of every output against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("pkt_valid", PKT'(pkt_valid), PKT'(m_valid));
         chk("locked", PKT'(locked), PKT'(m_locked));
         chk("overflow", PKT'(overflow), PKT'(m_ovf));
         chk("pkt_data", pkt_data, m_data);
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
         chk("inverted", PKT'(inverted), PKT'(m_inv));
`endif
      end
   end

   // DUT-side monitors: overflow pulses and accepted packets.
   int ovf_cnt = 0;
   int acc_cnt = 0;
   logic [PKT-1:0] acc_data = '0;
   logic prev_valid = 1'b0;
   logic [PKT-1:0] prev_data = '0;
   initial forever begin
      @(negedge clk);
      if (overflow === 1'b1) ovf_cnt++;
      if (prev_valid === 1'b1 && pkt_ready === 1'b1) begin
         acc_cnt++;
         acc_data = prev_data;
      end
      prev_valid = pkt_valid;
      prev_data = pkt_data;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b, input int idle);
      @(negedge clk); #1;
      bit_in = b;
      bit_valid = 1'b1;
      if (rnd) pkt_ready = 1'($urandom_range(0, 1));
      repeat (idle) begin
         @(negedge clk); #1;
         bit_valid = 1'b0;
         if (rnd) pkt_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk); #1;
         bit_valid = 1'b0;
      end
   endtask

   task automatic send_range(input logic [PKT-1:0] w, input int first, input int last, input int idle);
      for (int i = first; i <= last; i++) send_bit(w[PKT-1-i], idle);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rstn = 1'b0;
      bit_valid = 1'b0;
      @(negedge clk); #1;
      rstn = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".pkt_valid"}, PKT'(pkt_valid), '0);
      chk({tag, ".locked"}, PKT'(locked), '0);
      chk({tag, ".overflow"}, PKT'(overflow), '0);
      chk({tag, ".pkt_data"}, pkt_data, '0);
   endtask

   initial begin
      logic [PKT-1:0] rp;
      logic b, last_b;
      int run;

      // Reset state
      @(negedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk); #1;
      rstn = 1'b1;
      chk_zero("reset");

      // Sync then packet, one strobe every 4 cycles
      pkt_ready = 1'b1;
      send_range(p1, 0, 6, 3);
      chk("t1.locked_before_sync", PKT'(locked), '0);
      send_range(p1, 7, 7, 3);
      chk("t1.locked_after_sync", PKT'(locked), PKT'(1));
      send_range(p1, 8, 190, 3);
      send_bit(p1[0], 1);
      chk("t1.pkt_valid", PKT'(pkt_valid), PKT'(1));
      chk("t1.pkt_data", pkt_data, 192'hff5468697320697320612074657374206d65737361676521);
      chk("t1.unlocked", PKT'(locked), '0);
      idle_cycles(1);
      chk("t1.consumed", PKT'(pkt_valid), '0);

      // False sync rejection: no run of 8 equal bits, starting with 1
      do_reset();
      last_b = 1'b0;
      run = 0;
      for (int i = 0; i < 40; i++) begin
         b = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (i > 0 && b == last_b && run == 7) b = ~b;
         run = (i > 0 && b == last_b) ? run + 1 : 1;
         last_b = b;
         send_bit(b, 1);
         chk("t2.locked", PKT'(locked), '0);
         chk("t2.pkt_valid", PKT'(pkt_valid), '0);
      end

      // Backpressure and overflow
      do_reset();
      pkt_ready = 1'b0;
      ovf_cnt = 0;
      send_range(p1, 0, PKT-1, 1);
      send_range(p2, 0, PKT-1, 1);
      idle_cycles(3);
      chk("t3.ovf_pulses", PKT'(ovf_cnt), PKT'(1));
      chk("t3.held_valid", PKT'(pkt_valid), PKT'(1));
      chk("t3.held_data", pkt_data, p1);
      acc_cnt = 0;
      @(negedge clk); #1;
      pkt_ready = 1'b1;
      @(negedge clk); #1;
      pkt_ready = 1'b0;
      chk("t3.consumed", PKT'(pkt_valid), '0);
      chk("t3.acc_cnt", PKT'(acc_cnt), PKT'(1));
      chk("t3.acc_data", acc_data, p1);
      chk("t3.data_retained", pkt_data, p1);

      // Simultaneous consume and complete
      do_reset();
      pkt_ready = 1'b0;
      send_range(p1, 0, PKT-1, 1);
      send_range(p2, 0, PKT-2, 1);
      ovf_cnt = 0;
      @(negedge clk); #1;
      bit_in = p2[0];
      bit_valid = 1'b1;
      pkt_ready = 1'b1;
      @(negedge clk); #1;
      bit_valid = 1'b0;
      pkt_ready = 1'b0;
      chk("t4.valid", PKT'(pkt_valid), PKT'(1));
      chk("t4.data", pkt_data, p2);
      chk("t4.overflow", PKT'(overflow), '0);
      chk("t4.ovf_cnt", PKT'(ovf_cnt), '0);

      // Reset mid-packet
      do_reset();
      pkt_ready = 1'b1;
      acc_cnt = 0;
      send_range(p1, 0, SYNC + 100 - 1, 1);
      do_reset();
      chk_zero("t5");
      send_range(p2, 0, PKT-1, 1);
      idle_cycles(3);
      chk("t5.acc_cnt", PKT'(acc_cnt), PKT'(1));
      chk("t5.acc_data", acc_data, p2);

      // Inverted stream (phase ambiguity)
      do_reset();
      pkt_ready = 1'b1;
      acc_cnt = 0;
      pn = ~p1;
      for (int i = 0; i < 8; i++) send_bit(1'(i % 2 == 0), 1);
      send_range(pn, 0, SYNC-1, 1);
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
      chk("t6.locked", PKT'(locked), PKT'(1));
      chk("t6.inverted", PKT'(inverted), PKT'(1));
`endif
      send_range(pn, SYNC, PKT-1, 1);
      idle_cycles(3);
`ifdef PACKET_DEFRAMER_PHASE_RESOLVE_EN
      chk("t6.acc_cnt", PKT'(acc_cnt), PKT'(1));
      chk("t6.acc_data", acc_data, 192'hff5468697320697320612074657374206d65737361676521);
      chk("t6.inverted_clear", PKT'(inverted), '0);
`else
      chk("t6.acc_cnt", PKT'(acc_cnt), '0);
      chk("t6.locked", PKT'(locked), '0);
      chk("t6.pkt_valid", PKT'(pkt_valid), '0);
`endif

      // Randomized traffic against the model
      rnd = 1'b1;
      for (int it = 0; it < 30; it++) begin
         int choice;
         choice = $urandom_range(0, 9);
         if (choice < 6) begin
            rp = p2;
            for (int i = 0; i < PAY; i++) rp[i] = 1'($urandom_range(0, 1));
            for (int i = 0; i < PKT; i++) send_bit(rp[PKT-1-i], $urandom_range(0, 2));
         end else if (choice < 9) begin
            for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
         end else begin
            do_reset();
         end
         idle_cycles($urandom_range(1, 4));
      end
      rnd = 1'b0;
      pkt_ready = 1'b1;
      idle_cycles(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/packet_deframer.md
Name: packet_deframer

Overview:
- Sits directly downstream of the BPSK demodulator in `reciever`. It consumes the recovered bit stream and hunts for the sync header.
- After the header it collects one fixed-length packet and presents it as a parallel word with a valid/ready handshake.
- It is the mirror image of `packet_serializer`. Bits arrive MSB-first, and the sync byte forms the top bits of the packet.

Parameters:
- PACKET_SIZE, 192, total packet bits including sync header.
- SYNC_WIDTH, 8, sync header width in bits.
- SYNC_WORD, 8'hFF, header pattern. Occupies pkt_data[PACKET_SIZE-1 -: SYNC_WIDTH].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- bit_in  input  1  demodulated data bit; sampled only when bit_valid=1.
- bit_valid  input  1  single-cycle strobe, one per recovered symbol.
- pkt_data  output  PACKET_SIZE  assembled packet, MSB = first received bit.
- pkt_valid  output  1  pkt_data holds an unconsumed packet.
- pkt_ready  input  1  consumer accepts pkt_data when pkt_valid&&pkt_ready.
- locked  output  1  high while in COLLECT state.
- overflow  output  1  one-cycle pulse when a completed packet is dropped.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=HUNT, hunt shift register=0, bit counter=0.
  - pkt_data=0, pkt_valid=0, locked=0, overflow=0.
  - Reset mid-packet discards the partial packet and any held packet.
- HUNT state:
  - On each bit_valid, shift bit_in into the SYNC_WIDTH-bit hunt register from the LSB end.
  - Compare the post-shift value with SYNC_WORD.
  - On a match, go to COLLECT the next cycle, with counter=0 and locked=1.
  - Bits without bit_valid are ignored in every state.
- COLLECT state:
  - On each bit_valid, shift bit_in into the payload register (PACKET_SIZE-SYNC_WIDTH bits, LSB end) and increment the counter.
  - The bit that takes the counter to PACKET_SIZE-SYNC_WIDTH completes the packet.
  - On completion the state returns to HUNT, the hunt register clears to 0, and locked drops on the next cycle.
  - Back-to-back packets each require a full fresh header. A header overlapping the previous payload is never matched.
- Completion latency:
  - pkt_data={SYNC_WORD, payload} and pkt_valid=1 are visible the cycle after the edge that sampled the final bit.
- Output buffer (one deep):
  - pkt_valid clears on the edge where pkt_valid&&pkt_ready, unless a new completion occurs on the same edge.
  - In that case the new packet loads and pkt_valid stays 1.
  - If a packet completes while pkt_valid=1 and pkt_ready=0, the new packet is dropped and the held packet is kept.
  - The drop raises overflow for exactly one cycle. The state machine still returns to HUNT.
- pkt_data stability: holds its value while pkt_valid=1 and not consumed; retains its last value after consumption.
- Counter width: $clog2(PACKET_SIZE-SYNC_WIDTH+1). It never wraps, because completion resets it.

Optional Feature:
- Macro: PACKET_DEFRAMER_PHASE_RESOLVE_EN.
- With the macro defined:
  - HUNT also matches ~SYNC_WORD, which indicates BPSK 180° phase ambiguity.
  - On an inverted match, an internal invert flag is set and all COLLECT bits are stored as ~bit_in.
  - pkt_data is therefore identical to the non-inverted case. The flag clears on return to HUNT.
  - An extra output port `inverted` (1 bit, reset 0) mirrors the flag while locked.
- Without the macro:
  - Only a true SYNC_WORD match locks, and there is no `inverted` port.
  - An inverted stream never locks.

Decomposition:
- Shared package `bpsk_pkg`:
  - PACKET_SIZE, SYNC_WIDTH and SYNC_WORD constants, shared with packet_serializer and signal_modulator.
  - Typedef `deframer_state_t` enum {HUNT, COLLECT}.
  - Typedef `packet_t` = logic [PACKET_SIZE-1:0].
- One natural sub-module, `sync_detector`: the hunt shift register plus comparator(s), clear input, and match/inverted_match outputs.
- Collect counter and output buffer stay in the top module.

Test Plan:
- Sync then packet:
  - Stimulus: bits of 192'hff5468697320697320612074657374206d65737361676521 MSB-first, one bit_valid every 4 cycles, pkt_ready=1.
  - Response: pkt_valid for 1 cycle, exactly one cycle after the final bit; pkt_data equals the sent word; locked rises after bit 8.
- False sync rejection:
  - Stimulus: 40 random bits containing no 8'hFF window, with pkt_ready=1.
  - Response: locked=0 and pkt_valid=0 throughout.
- Backpressure and overflow:
  - Stimulus: two back-to-back packets (payloads "This is a test message!" and all-0x55), pkt_ready=0.
  - Response: first packet held in pkt_data; overflow pulses once on completion of the second; raising pkt_ready consumes the first packet only.
- Simultaneous consume and complete:
  - Stimulus: pkt_ready asserted on the same edge that samples the final bit of packet 2.
  - Response: pkt_valid stays 1, pkt_data becomes packet 2, overflow=0.
- Reset mid-packet:
  - Stimulus: rstn=0 for 1 cycle after 100 payload bits, then a full valid packet.
  - Response: all outputs 0 after reset; only the complete second packet is emitted.
- Phase resolve (macro defined):
  - Stimulus: bitwise-inverted test packet.
  - Response: pkt_data = original 192'hff54…21 and inverted=1 while locked. With the macro undefined: no lock, pkt_valid stays 0.
